// File: rtl/uart_receiver.sv
// UART receive engine: 2-flop rx synchronizer, 16x oversampled deframing, holding register with
// valid/read handshake plus framing/parity/overrun status. Parity is built only with UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    // state    | meaning
    // S_IDLE   | line idle, waiting for a synced 1->0 edge
    // S_START  | counting to mid start bit to confirm it is still low
    // S_DATA   | sampling DATA_BITS data bits at mid-bit, LSB first
    // S_PARITY | sampling the parity bit (parity builds only)
    // S_STOP   | sampling the stop bit, then commit and return to idle
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    localparam int TW = ($clog2(OVERSAMPLE) < 4) ? 4 : $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    state_t               state;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 mid_tick;
    logic                 commit;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign mid_tick = baud_tick && (tcnt == TW'(OVERSAMPLE - 1));
    assign commit   = (state == S_STOP) && mid_tick;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            tcnt         <= '0;
            bcnt         <= '0;
            shreg        <= '0;
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            case (state)
                S_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        tcnt  <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        if (tcnt == TW'(OVERSAMPLE / 2 - 1)) begin
                            tcnt  <= '0;
                            state <= rx_sync ? S_IDLE : S_DATA;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (mid_tick) begin
                        tcnt  <= '0;
                        shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                        if (bcnt == BW'(DATA_BITS - 1)) begin
                            bcnt  <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end else if (baud_tick) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (mid_tick) begin
                        tcnt    <= '0;
                        par_bit <= rx_sync;
                        state   <= S_STOP;
                    end else if (baud_tick) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // No wait for the end of the stop bit so back-to-back frames are caught.
                    if (mid_tick) begin
                        tcnt  <= '0;
                        state <= S_IDLE;
                    end else if (baud_tick) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (commit) begin
                if (!rx_valid || rx_read) begin
                    rx_data      <= shreg;
                    rx_frame_err <= ~rx_sync;
                    rx_valid     <= 1'b1;
                    rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    rx_parity_err <= par_bit ^ (^shreg) ^ PARITY_ODD;
`endif
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_read && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level reference model checked every cycle, plus literal checks
// on the directed cases (reset, 0xA5, false start, break/framing, overrun, reset mid-frame, parity).
module tb_uart_receiver;

    localparam int DB     = 8;
    localparam int OS     = 16;
    localparam int TDIV   = 3;
    localparam int BITCLK = OS * TDIV;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          baud_tick = 1'b0;
    logic          rx = 1'b1;
    logic          rx_read = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_parity_err;
    logic          rx_overrun;

    logic [DB-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    logic          m_fe = 1'b0;
    logic          m_pe = 1'b0;
    logic          m_ov = 1'b0;
    logic          check_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef UART_RX_PARITY_EN
    uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS), .PARITY_ODD(1'b0)) dut (
`else
    uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
`endif
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx), .rx_read(rx_read),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            baud_tick = (k == 0);
            k = (k + 1) % TDIV;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            n_cmp++;
            if ({rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun} !==
                {m_data, m_valid, m_fe, m_pe, m_ov}) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t got data=%h v=%b fe=%b pe=%b ov=%b want data=%h v=%b fe=%b pe=%b ov=%b",
                         $time, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun,
                         m_data, m_valid, m_fe, m_pe, m_ov);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic even_par(input logic [DB-1:0] d);
        return ^d;
    endfunction

    // A completed frame as seen from the register side.
    task automatic model_commit(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
        if (!m_valid) begin
            m_data  = d;
            m_valid = 1'b1;
            m_fe    = !stop_b;
`ifdef UART_RX_PARITY_EN
            m_pe    = par_b ^ even_par(d);
`else
            m_pe    = 1'b0;
`endif
        end else begin
            m_ov = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
        @(negedge clk);
        rx = 1'b0;
        repeat (BITCLK) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            repeat (BITCLK) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_b;
        repeat (BITCLK) @(negedge clk);
`endif
        check_en = 1'b0;
        rx = stop_b;
        repeat (BITCLK) @(negedge clk);
        rx = 1'b1;
        model_commit(d, stop_b, par_b);
        check_en = 1'b1;
    endtask

    task automatic do_read();
        @(negedge clk);
        rx_read = 1'b1;
        @(posedge clk);
        #1;
        rx_read = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ov    = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [DB-1:0] pat [4] = '{8'hFF, 8'h00, 8'h5A, 8'h96};

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", int'(rx_data), 0);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_flags", int'({rx_frame_err, rx_parity_err, rx_overrun}), 0);
        check_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        idle(20);

        send_frame(8'hA5, 1'b1, even_par(8'hA5));
        chk("a5_data", int'(rx_data), 'hA5);
        chk("a5_valid", int'(rx_valid), 1);
        chk("a5_flags", int'({rx_frame_err, rx_parity_err, rx_overrun}), 0);
        do_read();
        chk("a5_read_valid", int'(rx_valid), 0);

        @(negedge clk);
        rx = 1'b0;
        repeat (4 * TDIV) @(negedge clk);
        rx = 1'b1;
        idle(2 * BITCLK);
        chk("false_start_valid", int'(rx_valid), 0);

        send_frame(8'h81, 1'b0, even_par(8'h81));
        chk("brk_data", int'(rx_data), 'h81);
        chk("brk_valid", int'(rx_valid), 1);
        chk("brk_frame_err", int'(rx_frame_err), 1);
        idle(BITCLK);
        do_read();

        send_frame(8'h11, 1'b1, even_par(8'h11));
        send_frame(8'h22, 1'b1, even_par(8'h22));
        chk("ovr_data", int'(rx_data), 'h11);
        chk("ovr_valid", int'(rx_valid), 1);
        chk("ovr_overrun", int'(rx_overrun), 1);
        chk("ovr_frame_err", int'(rx_frame_err), 0);
        do_read();
        chk("ovr_read_valid", int'(rx_valid), 0);
        chk("ovr_read_overrun", int'(rx_overrun), 0);

        for (int i = 0; i < 4; i++) begin
            send_frame(pat[i], 1'b1, even_par(pat[i]));
            chk("pattern_data", int'(rx_data), int'(pat[i]));
            idle(10);
            do_read();
        end

        send_frame(8'h5A, 1'b1, even_par(8'h5A));
        @(negedge clk);
        rx = 1'b0;
        repeat (BITCLK) @(negedge clk);
        rx = 1'b1;
        repeat (BITCLK) @(negedge clk);
        rx = 1'b0;
        repeat (BITCLK / 2) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        m_data = '0; m_valid = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
        chk("midrst_data", int'(rx_data), 0);
        chk("midrst_valid", int'(rx_valid), 0);
        chk("midrst_flags", int'({rx_frame_err, rx_parity_err, rx_overrun}), 0);
        @(negedge clk);
        rst = 1'b1;
        idle(2 * BITCLK);
        chk("midrst_idle_valid", int'(rx_valid), 0);
        send_frame(8'h3C, 1'b1, even_par(8'h3C));
        chk("after_rst_data", int'(rx_data), 'h3C);
        chk("after_rst_valid", int'(rx_valid), 1);
        do_read();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        chk("par_ok_data", int'(rx_data), 'h07);
        chk("par_ok_err", int'(rx_parity_err), 0);
        do_read();
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par_bad_err", int'(rx_parity_err), 1);
        do_read();
`endif

        idle(20);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
